// File: rtl/btn_pkg.sv
// Shared types for the button debouncer bank.
// The hold FSM walks IDLE -> WAIT_FIRST -> REPEATING while a button stays pressed.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      REPEATING  = 2'd2
   } hold_state_e;

endpackage

// File: rtl/btn_debouncer_bank_if.sv
// Bundle of the clock enable, raw buttons and per-channel event outputs.
// No handshake: ce qualifies every sample; event outputs are one-ce-period pulses.
interface btn_debouncer_bank_if
   import btn_pkg::*;
#(
   parameter int CHANNELS = 4
) ();

   logic                ce;
   logic [CHANNELS-1:0] btn;
   logic [CHANNELS-1:0] btn_debounced;
   logic [CHANNELS-1:0] btn_press;
   logic [CHANNELS-1:0] btn_release;
   logic [CHANNELS-1:0] btn_repeat;
   hold_state_e [CHANNELS-1:0] hold_state;

   modport master (
      output ce, btn,
      input  btn_debounced, btn_press, btn_release, btn_repeat, hold_state
   );

   modport slave (
      input  ce, btn,
      output btn_debounced, btn_press, btn_release, btn_repeat, hold_state
   );

endinterface

// File: rtl/btn_channel.sv
// One button: synchronizer, symmetric counter-based debounce filter, and
// the hold FSM that produces auto-repeat pulses while the button stays pressed.
module btn_channel
   import btn_pkg::*;
#(
   parameter int COUNTER_WIDTH = 16,
   parameter int HOLD_WIDTH    = 16,
   parameter int REPEAT_DELAY  = 25000,
   parameter int REPEAT_PERIOD = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        btn,
   output logic        debounced,
   output logic        press_evt,
   output logic        release_evt,
   output logic        repeat_evt,
   output hold_state_e state
);

   localparam longint HOLD_MAX = (longint'(1) << HOLD_WIDTH) - 1;
   localparam logic [HOLD_WIDTH-1:0] DELAY_V  = HOLD_WIDTH'(REPEAT_DELAY);
   localparam logic [HOLD_WIDTH-1:0] PERIOD_V = HOLD_WIDTH'(REPEAT_PERIOD);

   if (longint'(REPEAT_DELAY) > HOLD_MAX) begin : g_bad_delay
      $error("REPEAT_DELAY does not fit in the hold counter");
   end
   if (longint'(REPEAT_PERIOD) > HOLD_MAX || REPEAT_PERIOD < 1) begin : g_bad_period
      $error("REPEAT_PERIOD must be in 1 .. 2**HOLD_WIDTH-1");
   end

   logic                     sync_q;
   logic [COUNTER_WIDTH-1:0] cnt;
   logic [HOLD_WIDTH-1:0]    hold_cnt;
   logic [HOLD_WIDTH-1:0]    hold_next;
   logic                     flip;

   btn_sync u_sync (
      .clk (clk),
      .ce  (ce),
      .d   (btn),
      .q   (sync_q)
   );

   // flip marks the sample on which the debounced level toggles
   always_comb begin
      flip      = (sync_q != debounced) && (&cnt);
      hold_next = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         hold_cnt    <= '0;
         debounced   <= 1'b0;
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
         repeat_evt  <= 1'b0;
         state       <= IDLE;
      end else if (ce) begin
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
         repeat_evt  <= 1'b0;

         if (sync_q == debounced) begin
            cnt <= '0;
         end else if (&cnt) begin
            cnt         <= '0;
            debounced   <= ~debounced;
            press_evt   <= ~debounced;
            release_evt <= debounced;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // A release wins over a repeat falling due on the same sample
         if (flip && debounced) begin
            state    <= IDLE;
            hold_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (flip && REPEAT_DELAY != 0) begin
                     state    <= WAIT_FIRST;
                     hold_cnt <= '0;
                  end
               end
               WAIT_FIRST: begin
                  if (hold_next == DELAY_V) begin
                     repeat_evt <= 1'b1;
                     hold_cnt   <= '0;
                     state      <= REPEATING;
                  end else begin
                     hold_cnt <= hold_next;
                  end
               end
               REPEATING: begin
                  if (hold_next == PERIOD_V) begin
                     repeat_evt <= 1'b1;
                     hold_cnt   <= '0;
                  end else begin
                     hold_cnt <= hold_next;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/btn_sync.sv
// Two-flop synchronizer advancing only on ce.
// Deliberately unreset: stale contents are absorbed by the debounce filter length.
module btn_sync (
   input  logic clk,
   input  logic ce,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (ce) begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_debouncer_bank.sv
// Bank of independent debounced buttons with press/release/auto-repeat events.
module btn_debouncer_bank
   import btn_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int COUNTER_WIDTH = 16,
   parameter int HOLD_WIDTH    = 16,
   parameter int REPEAT_DELAY  = 25000,
   parameter int REPEAT_PERIOD = 5000
) (
   input  logic                 clk,
   input  logic                 rst,
   btn_debouncer_bank_if.slave  bus
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      btn_channel #(
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .HOLD_WIDTH    (HOLD_WIDTH),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .ce          (bus.ce),
         .btn         (bus.btn[i]),
         .debounced   (bus.btn_debounced[i]),
         .press_evt   (bus.btn_press[i]),
         .release_evt (bus.btn_release[i]),
         .repeat_evt  (bus.btn_repeat[i]),
         .state       (bus.hold_state[i])
      );
   end

endmodule

// File: tb/tb_btn_debouncer_bank.sv
// Scenario bench for btn_debouncer_bank with a 4-sample filter, delay 5, period 3.
// Output word per edge: {debounced[1:0], press[1:0], release[1:0], repeat[1:0]}.
module tb_btn_debouncer_bank;
   import btn_pkg::*;

   localparam int CH = 2;
   localparam int CW = 2;
   localparam int HW = 16;
   localparam int RD = 5;
   localparam int RP = 3;

   logic clk;
   logic rst;
   int   check_cnt = 0;
   int   pass_cnt  = 0;
   logic [7:0] exp_q[$];
   logic [4:0] bounce = 5'b01101;

   btn_debouncer_bank_if #(.CHANNELS(CH)) bus ();

   btn_debouncer_bank #(
      .CHANNELS      (CH),
      .COUNTER_WIDTH (CW),
      .HOLD_WIDTH    (HW),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pack(input logic [1:0] d, input logic [1:0] p,
                                       input logic [1:0] r, input logic [1:0] q);
      return {d, p, r, q};
   endfunction

   function automatic logic [7:0] observe();
      return {bus.btn_debounced, bus.btn_press, bus.btn_release, bus.btn_repeat};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.ce  = 1'b1;
      bus.btn = '0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      do_reset();
      got = observe();
      check_cnt++;
      if (got !== 8'h00) $display("FAIL reset_outputs: got %b expected %b", got, 8'h00);
      else pass_cnt++;
      check_cnt++;
      if (bus.hold_state !== {IDLE, IDLE})
         $display("FAIL reset_state: got %b expected %b", bus.hold_state, {IDLE, IDLE});
      else pass_cnt++;
   endtask

   // Bounce, press, repeats, 3-cycle glitch, then release landing on a repeat slot
   task automatic test_bounce_repeat();
      logic [7:0] got, exp;
      logic b;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         if (k < 5) b = bounce[k];
         else b = ((k >= 20 && k <= 22) || k >= 31) ? 1'b0 : 1'b1;
         bus.btn = {1'b0, b};
         exp_q.push_back(pack({1'b0, (k >= 10 && k < 36)}, {1'b0, (k == 10)},
                              {1'b0, (k == 36)},
                              {1'b0, (k >= 15 && k <= 33 && (k - 15) % 3 == 0)}));
         tick();
         got = observe();
         exp = exp_q.pop_front();
         check_cnt++;
         if (got !== exp) $display("FAIL bounce_repeat k=%0d: got %b expected %b", k, got, exp);
         else pass_cnt++;
      end
   endtask

   // Same bounce with ce every third clock; every pulse spans three clocks
   task automatic test_ce_scaled();
      logic [7:0] got, exp;
      do_reset();
      for (int j = 0; j < 17; j++) begin
         for (int r = 0; r < 3; r++) begin
            bus.ce  = (r == 0);
            bus.btn = {1'b0, (j < 5) ? bounce[j] : 1'b1};
            exp_q.push_back(pack({1'b0, (j >= 10)}, {1'b0, (j == 10)}, 2'b00,
                                 {1'b0, (j == 15)}));
            tick();
            got = observe();
            exp = exp_q.pop_front();
            check_cnt++;
            if (got !== exp)
               $display("FAIL ce_scaled j=%0d r=%0d: got %b expected %b", j, r, got, exp);
            else pass_cnt++;
         end
      end
      bus.ce = 1'b1;
   endtask

   // Reset (with ce low) while repeating; button stays held afterwards
   task automatic test_reset_held();
      logic [7:0] got, exp;
      int first_press;
      do_reset();
      for (int k = 0; k < 18; k++) begin
         rst     = (k == 14);
         bus.ce  = (k != 14);
         bus.btn = 2'b01;
         if (k < 14)
            exp_q.push_back(pack({1'b0, (k >= 5)}, {1'b0, (k == 5)}, 2'b00,
                                 {1'b0, (k == 10 || k == 13)}));
         else
            exp_q.push_back(8'h00);
         tick();
         got = observe();
         exp = exp_q.pop_front();
         check_cnt++;
         if (got !== exp) $display("FAIL reset_held k=%0d: got %b expected %b", k, got, exp);
         else pass_cnt++;
      end
      rst    = 1'b0;
      bus.ce = 1'b1;
      first_press = -1;
      for (int k = 18; k <= 20; k++) begin
         tick();
         if (bus.btn_press[0] === 1'b1 && first_press < 0) first_press = k;
         check_cnt++;
         if (bus.btn_release !== 2'b00)
            $display("FAIL reset_no_release k=%0d: got %b expected 00", k, bus.btn_release);
         else pass_cnt++;
      end
      check_cnt++;
      if (first_press < 0)
         $display("FAIL reset_repress: got no press expected press within 4..6 samples of reset");
      else pass_cnt++;
   endtask

   // Simultaneous press on both channels, then only channel 1 released
   task automatic test_two_channels();
      logic [7:0] got, exp;
      logic rep0, rep1;
      do_reset();
      for (int k = 0; k < 24; k++) begin
         bus.btn = {(k < 12), 1'b1};
         rep0 = (k >= 10 && (k - 10) % 3 == 0);
         rep1 = rep0 && (k < 17);
         exp_q.push_back(pack({(k >= 5 && k < 17), (k >= 5)}, {(k == 5), (k == 5)},
                              {(k == 17), 1'b0}, {rep1, rep0}));
         tick();
         got = observe();
         exp = exp_q.pop_front();
         check_cnt++;
         if (got !== exp) $display("FAIL two_channels k=%0d: got %b expected %b", k, got, exp);
         else pass_cnt++;
      end
   endtask

   // Random runs of at most 3 high samples never get through the filter
   task automatic test_random_glitches();
      logic [7:0] got, exp;
      logic [1:0] lvl;
      int left[2];
      do_reset();
      lvl = 2'b00;
      left[0] = 0;
      left[1] = 0;
      for (int k = 0; k < 60; k++) begin
         for (int c = 0; c < 2; c++) begin
            if (left[c] == 0) begin
               lvl[c]  = ~lvl[c];
               left[c] = lvl[c] ? $urandom_range(1, 3) : $urandom_range(1, 4);
            end
            left[c]--;
         end
         bus.btn = lvl;
         exp_q.push_back(8'h00);
         tick();
         got = observe();
         exp = exp_q.pop_front();
         check_cnt++;
         if (got !== exp) $display("FAIL random_glitch k=%0d: got %b expected %b", k, got, exp);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst     = 1'b1;
      bus.ce  = 1'b1;
      bus.btn = '0;
      test_reset();
      test_bounce_repeat();
      test_ce_scaled();
      test_reset_held();
      test_two_channels();
      test_random_glitches();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
